uart_tx_fifo: RTL and testbench

UART transmitter peripheral for the pipelined CPU: the CPU-side store path writes bytes into a small FIFO, and the block serialises them onto `UART_TX` as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). It is the transmit counterpart of the CPU's `UART_RX` receive path and uses the same bit period, 5208 clocks of the 50 MHz `sysclk`, which is 9600 baud. Status outputs feed the peripheral register file so software can poll full/busy and detect lost writes.

---
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small write FIFO and polled status outputs.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_write,
  output logic                        tx_full,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic                        tx_done,
  output logic                        tx_overflow,
  output logic                        UART_TX
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          line_q, line_d;
  logic          push_c, pop_c, baud_last_c;
  logic [7:0]    mem_q [FIFO_DEPTH];

  // Next-state logic for the serialiser, FIFO pointers and registered status.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    baud_d      = baud_q;
    pop_c       = 1'b0;
    baud_last_c = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last_c) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          // A queued byte starts its frame straight from the stop bit.
          if (count_q != '0) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-edge pop never frees a slot for the write.
    push_c     = tx_write && (count_q != DEPTH_C);
    count_d    = count_q + CW'(push_c) - CW'(pop_c);
    wr_ptr_d   = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (tx_write & ~push_c);

    full_d = (count_d == DEPTH_C);
    busy_d = (state_d != IDLE) || (count_d != '0);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      baud_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      baud_q     <= baud_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      line_q     <= line_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge sysclk) begin
    if (push_c) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx_full     = full_q;
  assign tx_busy     = busy_q;
  assign tx_count    = count_q;
  assign tx_done     = done_q;
  assign tx_overflow = overflow_q;
  assign UART_TX     = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with an 8-clock bit period and 4-entry FIFO.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full, tx_busy, tx_done, tx_overflow, UART_TX;
  logic [2:0] tx_count;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .tx_count    (tx_count),
    .tx_done     (tx_done),
    .tx_overflow (tx_overflow),
    .UART_TX     (UART_TX)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge inside frame cycle index 'first' (0 = first start-bit cycle).
  // Checks line, done and busy every cycle; optionally drives a write sampled at the frame's final edge.
  task automatic frame(input logic [7:0] b, input int first, input logic inj, input logic [7:0] inj_data);
    logic exp_bit;
    for (int i = first; i < int'(FRAME); i++) begin
      if (i < int'(CPB))            exp_bit = 1'b0;
      else if (i < int'(9 * CPB))   exp_bit = b[(i - int'(CPB)) / int'(CPB)];
      else                          exp_bit = 1'b1;
      chk($sformatf("line b=%02h i=%0d", b, i), 32'(UART_TX), 32'(exp_bit));
      chk($sformatf("done b=%02h i=%0d", b, i), 32'(tx_done), 32'(i == int'(FRAME) - 1));
      chk($sformatf("busy b=%02h i=%0d", b, i), 32'(tx_busy), 32'd1);
      if (inj && i == int'(FRAME) - 1) begin
        tx_write = 1'b1;
        tx_data  = inj_data;
      end
      @(negedge sysclk);
    end
  endtask

  initial begin
    int lows;
    reset    = 1'b1;
    tx_write = 1'b0;
    tx_data  = 8'h00;

    // Reset values.
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    chk("rst line", 32'(UART_TX), 32'd1);
    chk("rst busy", 32'(tx_busy), 32'd0);
    chk("rst full", 32'(tx_full), 32'd0);
    chk("rst count", 32'(tx_count), 32'd0);
    chk("rst done", 32'(tx_done), 32'd0);
    chk("rst ovf", 32'(tx_overflow), 32'd0);

    // Single byte 0x18.
    tx_write = 1'b1; tx_data = 8'h18;
    @(negedge sysclk);
    tx_write = 1'b0;
    chk("single count", 32'(tx_count), 32'd1);
    chk("single line idle", 32'(UART_TX), 32'd1);
    chk("single busy", 32'(tx_busy), 32'd1);
    @(negedge sysclk);
    frame(8'h18, 0, 1'b0, 8'h00);
    chk("single after line", 32'(UART_TX), 32'd1);
    chk("single after busy", 32'(tx_busy), 32'd0);
    chk("single after done", 32'(tx_done), 32'd0);
    repeat (3) @(negedge sysclk);

    // Back-to-back 0x18, 0x78.
    tx_write = 1'b1; tx_data = 8'h18;
    @(negedge sysclk);
    tx_data = 8'h78;
    @(negedge sysclk);
    tx_write = 1'b0;
    chk("b2b count", 32'(tx_count), 32'd1);
    frame(8'h18, 0, 1'b0, 8'h00);
    chk("b2b count2", 32'(tx_count), 32'd0);
    frame(8'h78, 0, 1'b0, 8'h00);
    chk("b2b after line", 32'(UART_TX), 32'd1);
    chk("b2b after busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge sysclk);

    // Full and overflow: six writes on consecutive edges.
    for (int j = 1; j <= 6; j++) begin
      tx_write = 1'b1; tx_data = 8'(j);
      @(negedge sysclk);
    end
    tx_write = 1'b0;
    chk("ovf full", 32'(tx_full), 32'd1);
    chk("ovf flag", 32'(tx_overflow), 32'd1);
    chk("ovf count", 32'(tx_count), 32'd4);
    frame(8'h01, 4, 1'b0, 8'h00);
    chk("ovf count after f1", 32'(tx_count), 32'd3);
    chk("ovf full after f1", 32'(tx_full), 32'd0);
    for (int j = 2; j <= 5; j++) frame(8'(j), 0, 1'b0, 8'h00);
    chk("ovf after line", 32'(UART_TX), 32'd1);
    chk("ovf after busy", 32'(tx_busy), 32'd0);
    chk("ovf sticky", 32'(tx_overflow), 32'd1);
    repeat (3) @(negedge sysclk);

    // Simultaneous push and pop at the stop-to-start edge.
    tx_write = 1'b1; tx_data = 8'hA5;
    @(negedge sysclk);
    tx_data = 8'h3C;
    @(negedge sysclk);
    tx_data = 8'h81;
    @(negedge sysclk);
    tx_write = 1'b0;
    chk("pp count pre", 32'(tx_count), 32'd2);
    frame(8'hA5, 1, 1'b1, 8'h5A);
    tx_write = 1'b0;
    chk("pp count held", 32'(tx_count), 32'd2);
    frame(8'h3C, 0, 1'b0, 8'h00);
    frame(8'h81, 0, 1'b0, 8'h00);
    frame(8'h5A, 0, 1'b0, 8'h00);
    chk("pp after busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge sysclk);

    // Reset during data bit 3 with two bytes queued.
    tx_write = 1'b1; tx_data = 8'hFF;
    @(negedge sysclk);
    tx_data = 8'hF0;
    @(negedge sysclk);
    tx_data = 8'h0F;
    @(negedge sysclk);
    tx_write = 1'b0;
    repeat (34) @(negedge sysclk);
    chk("mid line bit3", 32'(UART_TX), 32'd1);
    chk("mid count", 32'(tx_count), 32'd2);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    chk("mid rst line", 32'(UART_TX), 32'd1);
    chk("mid rst count", 32'(tx_count), 32'd0);
    chk("mid rst busy", 32'(tx_busy), 32'd0);
    chk("mid rst ovf", 32'(tx_overflow), 32'd0);
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      if (UART_TX !== 1'b1 || tx_busy !== 1'b0) lows++;
      @(negedge sysclk);
    end
    chk("mid quiet cycles", 32'(lows), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
